mcpu_boot_loader: RTL and testbench
===================================

MCPU_BOOT_LOADER -- requirements
Module: mcpu_boot_loader

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the instruction word width.
REQ-002 Parameter ADDR_SIZE, default 8, SHALL set the RAM address width; MEM_DEPTH = 2**ADDR_SIZE (256).
REQ-003 Parameter RELEASE_CYCLES, default 2, SHALL set the number of cycles cpu_reset is held after the load completes.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a boot.
- in_valid  in  1  program word available.
- in_ready  out  1  loader accepts a word.
- in_data  in  WORD_SIZE  program word.
- in_last  in  1  marks the final program word.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_SIZE  RAM write address.
- mem_wdata  out  WORD_SIZE  RAM write data.
- cpu_reset  out  1  holds the MCPU in reset.
- busy  out  1  boot in progress.
- done  out  1  program loaded and CPU released.
- load_count  out  ADDR_SIZE+1  number of words accepted.
- overflow_err  out  1  program exceeded MEM_DEPTH.

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, LOAD, RELEASE, DONE and ERROR.
REQ-006 IDLE, DONE or ERROR with start=1 SHALL go to CLEAR next cycle, zero the address counter, load_count and overflow_err, and assert cpu_reset.
REQ-007 start SHALL be ignored in CLEAR, LOAD and RELEASE.
REQ-008 CLEAR SHALL issue one write per cycle: mem_we=1, mem_wdata=0, mem_addr 0 to MEM_DEPTH-1 ascending, then go to LOAD (MEM_DEPTH cycles).
REQ-009 in_ready SHALL be 1 only in LOAD; a transfer occurs on in_valid & in_ready.
REQ-010 Each transfer SHALL produce mem_we=1, mem_addr=word index, mem_wdata=in_data on the next cycle (registered, latency 1), and increment load_count.
REQ-011 With no transfer in LOAD, mem_we SHALL be 0 and addresses SHALL not advance.
REQ-012 A transfer with in_last=1 SHALL move LOAD to RELEASE; that word is still written.
REQ-013 The MEM_DEPTH-th transfer without in_last SHALL be written, then the FSM SHALL enter ERROR with overflow_err=1 and cpu_reset held at 1.
REQ-014 An in_last=1 on the MEM_DEPTH-th transfer SHALL be legal and go to RELEASE.
REQ-015 Address increment SHALL wrap modulo MEM_DEPTH; load_count SHALL saturate at MEM_DEPTH.
REQ-016 RELEASE SHALL hold cpu_reset=1 for RELEASE_CYCLES cycles, then enter DONE.
REQ-017 In DONE: cpu_reset=0, done=1, busy=0, load_count frozen.
REQ-018 busy SHALL be 1 exactly in CLEAR, LOAD and RELEASE.
REQ-019 A zero-word program is impossible; the loader SHALL wait in LOAD indefinitely, with cpu_reset=1, until the first transfer.

Reset
REQ-020 reset SHALL take priority over all inputs, including start.
REQ-021 reset SHALL force state IDLE and set cpu_reset=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, load_count=0, overflow_err=0.
REQ-022 reset asserted in CLEAR, LOAD or RELEASE SHALL abort with no further RAM writes; any write already registered that cycle SHALL be suppressed.

Structure
REQ-023 WORD_SIZE, ADDR_SIZE, MEM_DEPTH and the state encoding SHALL live in the shared mcpu_defs package/include used by the MCPU.
REQ-024 The block SHALL be a single module with no sub-module; its outputs connect to the RAM write port and the MCPU reset input.

Verification
REQ-025 reset 2 cycles, start -> 256 zero writes at addr 0..255; in_ready goes to 1 on cycle 257 after start.
REQ-026 Stream 20 words 0x1000..0x1013 with in_last on 0x1013 -> mem[0..19] hold those words, mem[20..255]=0, load_count=20, cpu_reset falls 2 cycles after the last write, done=1.
REQ-027 Toggle in_valid 1,0,0,1 over a 4-word program -> exactly 4 writes at addr 0..3, with no write in the gap cycles.
REQ-028 Send 256 words with no in_last -> 256 writes, then overflow_err=1, cpu_reset=1, done=0; a new start clears overflow_err.
REQ-029 Assert reset at word 5 of LOAD -> no write after that edge, all outputs at reset values, and a following start performs a full CLEAR.
REQ-030 start pulses during CLEAR and RELEASE -> ignored; the sequence and cycle counts are unchanged from REQ-026.

Source files
------------

// File: rtl/mcpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_defs
// Shared MCPU definitions: default instruction word width, RAM address width
// and depth, plus the state encoding used by the boot loader.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mcpu_defs;

    localparam int MCPU_WORD_SIZE = 16;
    localparam int MCPU_ADDR_SIZE = 8;
    localparam int MCPU_MEM_DEPTH = 2 ** MCPU_ADDR_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } boot_state_e;

    // The loader counts as busy only while a boot is actively running.
    function automatic logic state_is_busy(input boot_state_e s);
        return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/mcpu_boot_loader.sv
// ---------------------------------------------------------------------------
// mcpu_boot_loader
// Boots the MCPU: on start it zeroes the whole program RAM, then streams
// program words from a valid/ready source into RAM, and finally releases the
// CPU from reset after a short hold-off.  A program that fills the RAM
// without an in_last marker is flagged as an overflow and the CPU is kept in
// reset.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-high
//   start        - one-cycle pulse that begins a boot (IDLE/DONE/ERROR only)
//   in_valid     - program word available
//   in_ready     - loader accepts a word (LOAD state only)
//   in_data      - program word
//   in_last      - marks the final program word
//   mem_we       - RAM write strobe
//   mem_addr     - RAM write address
//   mem_wdata    - RAM write data
//   cpu_reset    - holds the MCPU in reset
//   busy         - boot in progress (CLEAR, LOAD, RELEASE)
//   done         - program loaded and CPU released
//   load_count   - number of words accepted, saturating at MEM_DEPTH
//   overflow_err - program exceeded MEM_DEPTH
// ---------------------------------------------------------------------------
module mcpu_boot_loader
    import mcpu_defs::*;
#(
    parameter int WORD_SIZE      = MCPU_WORD_SIZE,
    parameter int ADDR_SIZE      = MCPU_ADDR_SIZE,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE:0]   load_count,
    output logic                 overflow_err
);

    localparam int MEM_DEPTH = 2 ** ADDR_SIZE;
    localparam int CNT_W     = ADDR_SIZE + 1;
    localparam int REL_W     = 16;

    localparam logic [ADDR_SIZE-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MEM_DEPTH - 1);
    // A hold-off of zero cycles is treated as one so RELEASE is never skipped.
    localparam logic [REL_W-1:0]     REL_LAST =
        (RELEASE_CYCLES > 1) ? REL_W'(RELEASE_CYCLES - 1) : '0;

    boot_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [REL_W-1:0]       rel_cnt_q, rel_cnt_d;
    logic                   wr_we_q, wr_we_d;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0]   wr_data_q, wr_data_d;

    // State and datapath registers.  Reset also drops any LOAD write that
    // would otherwise appear on the RAM port in the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rel_cnt_q  <= '0;
            wr_we_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rel_cnt_q  <= rel_cnt_d;
            wr_we_q    <= wr_we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next-state and datapath update.  addr_q is the RAM pointer shared by
    // CLEAR (sweep 0..MEM_DEPTH-1) and LOAD (word index); the sweep wraps it
    // back to 0 exactly when LOAD begins.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rel_cnt_d  = rel_cnt_q;
        wr_we_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    addr_d     = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_MAX) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (in_valid) begin
                    wr_we_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + 1'b1;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + 1'b1;
                    end
                    // in_last wins over overflow so a program that exactly
                    // fills the RAM is still accepted.
                    if (in_last) begin
                        state_d   = ST_RELEASE;
                        rel_cnt_d = '0;
                    end else if (count_q == CNT_LAST) begin
                        state_d    = ST_ERROR;
                        overflow_d = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                if (rel_cnt_q >= REL_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.  CLEAR writes are driven straight from the sweep pointer
    // so the sweep lines up with the CLEAR state; LOAD writes come from the
    // registered write stage one cycle after the handshake.
    always_comb begin
        in_ready     = (state_q == ST_LOAD);
        busy         = state_is_busy(state_q);
        done         = (state_q == ST_DONE);
        cpu_reset    = (state_q != ST_DONE);
        load_count   = count_q;
        overflow_err = overflow_q;

        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_we_q;
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
        end
    end

endmodule

// File: tb/tb_mcpu_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_mcpu_boot_loader
// Directed bench for the boot loader: clear sweep, normal load, gapped
// handshake, overflow, and reset abort.  A RAM model captures every write
// seen on the DUT write port so the final RAM image can be compared with
// hand-computed contents.
// ---------------------------------------------------------------------------
module tb_mcpu_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [8:0]  load_count;
    logic        overflow_err;

    logic [15:0] ram [0:255];
    int          wr_cnt = 0;
    int          total  = 0;
    int          bad    = 0;

    mcpu_boot_loader #(
        .WORD_SIZE      (16),
        .ADDR_SIZE      (8),
        .RELEASE_CYCLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .load_count   (load_count),
        .overflow_err (overflow_err)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // RAM model: capture writes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic l, input logic [15:0] d);
        reset    = r;
        start    = s;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
        checkOutput({pfx, "_done"}, 32'(done), 32'd0);
        checkOutput({pfx, "_load_count"}, 32'(load_count), 32'd0);
        checkOutput({pfx, "_overflow"}, 32'(overflow_err), 32'd0);
    endtask

    // Start pulse plus the 256-cycle sweep; returns in the first LOAD cycle.
    task automatic runClear();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        repeat (256) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Linear sequence of directed steps.
    initial begin
        int errs;
        int wr_base;
        int k;
        int vseq [10];
        logic v;

        vseq = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 256; i++) ram[i] = 16'hBEEF;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        checkResetOutputs("rst");

        $display("[TB] clear sweep with start pulse during CLEAR");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checkOutput("clr1_busy", 32'(busy), 32'd1);
        checkOutput("clr1_we", 32'(mem_we), 32'd1);
        checkOutput("clr1_addr", 32'(mem_addr), 32'd0);
        checkOutput("clr1_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("clr1_in_ready", 32'(in_ready), 32'd0);
        for (int c = 2; c <= 256; c++) begin
            applyStimulus(1'b0, (c == 100), 1'b0, 1'b0, 16'h0);
        end
        checkOutput("clr256_in_ready", 32'(in_ready), 32'd0);
        checkOutput("clr256_addr", 32'(mem_addr), 32'd255);
        checkOutput("clr256_we", 32'(mem_we), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("c257_in_ready", 32'(in_ready), 32'd1);
        checkOutput("c257_we", 32'(mem_we), 32'd0);
        checkOutput("clr_writes", 32'(wr_cnt), 32'd256);
        errs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 16'h0) errs++;
        checkOutput("clr_image", 32'(errs), 32'd0);

        $display("[TB] 20-word program with start pulse during RELEASE");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, (i == 19), 16'h1000 + 16'(i));
            if (i == 9) begin
                checkOutput("ld10_count", 32'(load_count), 32'd10);
                checkOutput("ld10_addr", 32'(mem_addr), 32'd9);
                checkOutput("ld10_wdata", 32'(mem_wdata), 32'h1009);
            end
        end
        checkOutput("rel1_we", 32'(mem_we), 32'd1);
        checkOutput("rel1_addr", 32'(mem_addr), 32'd19);
        checkOutput("rel1_wdata", 32'(mem_wdata), 32'h1013);
        checkOutput("rel1_count", 32'(load_count), 32'd20);
        checkOutput("rel1_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rel1_cpu_reset", 32'(cpu_reset), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checkOutput("rel2_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rel2_busy", 32'(busy), 32'd1);
        checkOutput("rel2_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("done_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("done_done", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_count", 32'(load_count), 32'd20);
        checkOutput("prog_writes", 32'(wr_cnt), 32'd276);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== ((i < 20) ? 16'h1000 + 16'(i) : 16'h0)) errs++;
        end
        checkOutput("prog_image", 32'(errs), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
        checkOutput("done_hold_done", 32'(done), 32'd1);
        checkOutput("done_hold_count", 32'(load_count), 32'd20);
        checkOutput("done_hold_we", 32'(mem_we), 32'd0);

        $display("[TB] gapped handshake 1,0,0,1");
        runClear();
        wr_base = wr_cnt;
        k = 0;
        for (int j = 0; j < 10; j++) begin
            v = (vseq[j] == 1);
            applyStimulus(1'b0, 1'b0, v, v && (k == 3), 16'hA000 + 16'(k));
            checkOutput("gap_we", 32'(mem_we), 32'(v));
            if (v) begin
                checkOutput("gap_addr", 32'(mem_addr), 32'(k));
                checkOutput("gap_wdata", 32'(mem_wdata), 32'hA000 + 32'(k));
                k++;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("gap_done", 32'(done), 32'd1);
        checkOutput("gap_count", 32'(load_count), 32'd4);
        checkOutput("gap_writes", 32'(wr_cnt - wr_base), 32'd4);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== ((i < 4) ? 16'hA000 + 16'(i) : 16'h0)) errs++;
        end
        checkOutput("gap_image", 32'(errs), 32'd0);

        $display("[TB] overflow: 256 words without in_last");
        runClear();
        wr_base = wr_cnt;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h2000 + 16'(i));
            if (i == 254) begin
                checkOutput("ov255_busy", 32'(busy), 32'd1);
                checkOutput("ov255_overflow", 32'(overflow_err), 32'd0);
                checkOutput("ov255_in_ready", 32'(in_ready), 32'd1);
                checkOutput("ov255_count", 32'(load_count), 32'd255);
            end
        end
        checkOutput("ov_overflow", 32'(overflow_err), 32'd1);
        checkOutput("ov_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("ov_done", 32'(done), 32'd0);
        checkOutput("ov_busy", 32'(busy), 32'd0);
        checkOutput("ov_in_ready", 32'(in_ready), 32'd0);
        checkOutput("ov_we", 32'(mem_we), 32'd1);
        checkOutput("ov_addr", 32'(mem_addr), 32'd255);
        checkOutput("ov_wdata", 32'(mem_wdata), 32'h20FF);
        checkOutput("ov_count", 32'(load_count), 32'd256);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h7777);
        checkOutput("err_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("err_we2", 32'(mem_we), 32'd0);
        checkOutput("err_overflow", 32'(overflow_err), 32'd1);
        checkOutput("ov_writes", 32'(wr_cnt - wr_base), 32'd256);
        checkOutput("ov_ram0", 32'(ram[0]), 32'h2000);
        checkOutput("ov_ram255", 32'(ram[255]), 32'h20FF);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checkOutput("restart_overflow", 32'(overflow_err), 32'd0);
        checkOutput("restart_count", 32'(load_count), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);

        $display("[TB] reset abort at word 5");
        repeat (256) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        checkOutput("ab_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h3000 + 16'(i));
        end
        checkOutput("ab_we4", 32'(mem_we), 32'd1);
        checkOutput("ab_addr4", 32'(mem_addr), 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h3005);
        checkResetOutputs("abort");
        wr_base = wr_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h3006);
        checkOutput("ab_no_write", 32'(wr_cnt - wr_base), 32'd0);
        checkOutput("ab_ram4", 32'(ram[4]), 32'h3004);
        checkOutput("ab_ram5", 32'(ram[5]), 32'h0);
        wr_base = wr_cnt;
        runClear();
        checkOutput("ab_clear_writes", 32'(wr_cnt - wr_base), 32'd256);
        checkOutput("ab_clear_in_ready", 32'(in_ready), 32'd1);
        errs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 16'h0) errs++;
        checkOutput("ab_clear_image", 32'(errs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
